// File: rtl/fetch_queue_if.sv
// Handshake bundle between IF (master) and the fetch queue (slave).
// The slave side also carries occupancy status back to the master.
interface fetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              enq_valid;
  logic              enq_ready;
  logic [PC_W-1:0]   enq_pc_4;
  logic [DATA_W-1:0] enq_inst;
  logic              deq_valid;
  logic              deq_ready;
  logic [PC_W-1:0]   deq_pc_4;
  logic [DATA_W-1:0] deq_inst;
  logic              flush;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output enq_valid, enq_pc_4, enq_inst, deq_ready, flush,
    input  enq_ready, deq_valid, deq_pc_4, deq_inst, count, full, empty
  );

  modport slave (
    input  enq_valid, enq_pc_4, enq_inst, deq_ready, flush,
    output enq_ready, deq_valid, deq_pc_4, deq_inst, count, full, empty
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular IF->ID instruction queue with flush; optional same-cycle
// empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0000)
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = PC_W + DATA_W;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_bypass;
  logic             w_enq;
  logic             w_deq;
  logic             w_deq_valid;
  logic [ENT_W-1:0] w_head;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue with a consumer waiting: hand the fetched word straight through.
  assign w_bypass = w_empty && bus.enq_valid && bus.deq_ready && !bus.flush && !rst;
  assign w_head   = w_bypass ? {bus.enq_pc_4, bus.enq_inst} : r_mem[r_rptr];
`else
  assign w_bypass = 1'b0;
  assign w_head   = r_mem[r_rptr];
`endif

  assign w_deq_valid   = !w_empty || w_bypass;
  assign bus.enq_ready = !rst && !w_full;
  assign w_enq         = bus.enq_valid && bus.enq_ready && !bus.flush && !w_bypass;
  assign w_deq         = !w_empty && bus.deq_ready && !bus.flush;

  assign bus.deq_valid = w_deq_valid;
  assign bus.deq_pc_4  = w_deq_valid ? w_head[ENT_W-1:DATA_W] : '0;
  assign bus.deq_inst  = w_deq_valid ? w_head[DATA_W-1:0]     : NOP_WORD;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wptr] <= {bus.enq_pc_4, bus.enq_inst};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4); the bypass
// scenario follows whichever FETCH_QUEUE_BYPASS_EN build is compiled.
module tb_fetch_queue;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  fetch_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .DEPTH   (DEPTH),
    .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enq_valid = 1'b0;
    bus.enq_pc_4  = '0;
    bus.enq_inst  = '0;
    bus.deq_ready = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.enq_ready !== 1'b0) $display("FAIL reset_enq_ready_during got=%b exp=0", bus.enq_ready);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (bus.deq_valid !== 1'b0) $display("FAIL reset_deq_valid got=%b exp=0", bus.deq_valid);
    else n_pass++;
    n_total++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", bus.empty, bus.full);
    else n_pass++;
    n_total++;
    if (bus.count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", bus.count);
    else n_pass++;
    n_total++;
    if (bus.deq_inst !== NOP || bus.deq_pc_4 !== 32'h0) $display("FAIL reset_outputs got inst=%h pc=%h exp inst=%h pc=0", bus.deq_inst, bus.deq_pc_4, NOP);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.enq_ready !== 1'b1) $display("FAIL reset_enq_ready_after got=%b exp=1", bus.enq_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    bus.enq_valid = 1'b1;
    bus.enq_pc_4  = 32'h0000_0004;
    bus.enq_inst  = 32'h2008_0005;
    bus.deq_ready = 1'b0;
    #1;
    n_total++;
    if (bus.deq_valid !== 1'b0) $display("FAIL single_same_cycle got deq_valid=%b exp=0", bus.deq_valid);
    else n_pass++;
    tick();
    bus.enq_valid = 1'b0;
    #1;
    n_total++;
    if (bus.deq_valid !== 1'b1 || bus.deq_inst !== 32'h2008_0005 || bus.deq_pc_4 !== 32'h4 || bus.count !== 3'd1)
      $display("FAIL single_head got v=%b inst=%h pc=%h cnt=%0d exp v=1 inst=20080005 pc=4 cnt=1",
               bus.deq_valid, bus.deq_inst, bus.deq_pc_4, bus.count);
    else n_pass++;
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;
    #1;
    n_total++;
    if (bus.empty !== 1'b1) $display("FAIL single_drain got empty=%b exp=1", bus.empty);
    else n_pass++;
  endtask

  task automatic test_full();
    bus.deq_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_pc_4  = 32'(4 * i);
      bus.enq_inst  = 32'(32'h100 + i);
      tick();
    end
    bus.enq_pc_4 = 32'd20;
    bus.enq_inst = 32'h105;
    #1;
    n_total++;
    if (bus.full !== 1'b1 || bus.enq_ready !== 1'b0 || bus.count !== 3'd4)
      $display("FAIL full_flags got full=%b rdy=%b cnt=%0d exp full=1 rdy=0 cnt=4", bus.full, bus.enq_ready, bus.count);
    else n_pass++;
    tick();
    n_total++;
    if (bus.count !== 3'd4 || bus.deq_inst !== 32'h101) $display("FAIL full_hold got cnt=%0d head=%h exp cnt=4 head=101", bus.count, bus.deq_inst);
    else n_pass++;
    bus.deq_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_total++;
      if (bus.deq_valid !== 1'b1 || bus.deq_inst !== 32'(32'h100 + k) || bus.deq_pc_4 !== 32'(4 * k))
        $display("FAIL full_order_%0d got v=%b inst=%h pc=%h exp v=1 inst=%h pc=%h",
                 k, bus.deq_valid, bus.deq_inst, bus.deq_pc_4, 32'(32'h100 + k), 32'(4 * k));
      else n_pass++;
      if (k == 1) begin
        n_total++;
        if (bus.enq_ready !== 1'b0) $display("FAIL full_reject_with_deq got rdy=%b exp=0", bus.enq_ready);
        else n_pass++;
      end
      if (k == 2) begin
        n_total++;
        if (bus.enq_ready !== 1'b1 || bus.count !== 3'd3) $display("FAIL full_reopen got rdy=%b cnt=%0d exp rdy=1 cnt=3", bus.enq_ready, bus.count);
        else n_pass++;
      end
      tick();
      if (k == 2) bus.enq_valid = 1'b0;
    end
    bus.deq_ready = 1'b0;
    #1;
    n_total++;
    if (bus.empty !== 1'b1 || bus.deq_valid !== 1'b0) $display("FAIL full_drained got empty=%b v=%b exp empty=1 v=0", bus.empty, bus.deq_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_pc_4  = 32'(32'h40 + 4 * i);
      bus.enq_inst  = 32'(32'hA0 + i);
      tick();
    end
    n_total++;
    if (bus.count !== 3'd3) $display("FAIL flush_prefill got cnt=%0d exp=3", bus.count);
    else n_pass++;
    bus.flush     = 1'b1;
    bus.enq_inst  = 32'hDEAD_BEEF;
    bus.enq_pc_4  = 32'h0000_0100;
    bus.deq_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    #1;
    n_total++;
    if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0 || bus.deq_inst !== NOP || bus.deq_pc_4 !== 32'h0)
      $display("FAIL flush_result got cnt=%0d v=%b inst=%h pc=%h exp cnt=0 v=0 inst=%h pc=0",
               bus.count, bus.deq_valid, bus.deq_inst, bus.deq_pc_4, NOP);
    else n_pass++;
    tick();
    n_total++;
    if (bus.empty !== 1'b1 || bus.deq_valid !== 1'b0) $display("FAIL flush_no_ghost got empty=%b v=%b exp empty=1 v=0", bus.empty, bus.deq_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] w;
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = 32'(32'h5000 + i);
      bus.enq_valid = 1'b1;
      bus.enq_pc_4  = w;
      bus.enq_inst  = w;
      exp_q.push_back(w);
      tick();
    end
    bus.deq_ready = 1'b1;
    for (int c = 0; c < 3 * DEPTH; c++) begin
      w = 32'(32'h5002 + c);
      bus.enq_pc_4 = w;
      bus.enq_inst = w;
      #1;
      n_total++;
      if (bus.deq_valid !== 1'b1 || bus.deq_inst !== exp_q[0] || bus.deq_pc_4 !== exp_q[0] || bus.count !== 3'd2)
        $display("FAIL b2b_cycle_%0d got v=%b inst=%h pc=%h cnt=%0d exp v=1 inst=%h cnt=2",
                 c, bus.deq_valid, bus.deq_inst, bus.deq_pc_4, bus.count, exp_q[0]);
      else n_pass++;
      exp_q.push_back(w);
      void'(exp_q.pop_front());
      tick();
    end
    bus.enq_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_total++;
      if (bus.deq_inst !== exp_q[0]) $display("FAIL b2b_drain_%0d got=%h exp=%h", c, bus.deq_inst, exp_q[0]);
      else n_pass++;
      void'(exp_q.pop_front());
      tick();
    end
    bus.deq_ready = 1'b0;
    #1;
    n_total++;
    if (bus.empty !== 1'b1) $display("FAIL b2b_empty got empty=%b exp=1", bus.empty);
    else n_pass++;
  endtask

  task automatic test_bypass();
    bus.enq_valid = 1'b1;
    bus.enq_pc_4  = 32'h0000_0800;
    bus.enq_inst  = 32'h1234_5678;
    bus.deq_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    n_total++;
    if (bus.deq_valid !== 1'b1 || bus.deq_inst !== 32'h1234_5678 || bus.deq_pc_4 !== 32'h800)
      $display("FAIL bypass_same_cycle got v=%b inst=%h pc=%h exp v=1 inst=12345678 pc=800", bus.deq_valid, bus.deq_inst, bus.deq_pc_4);
    else n_pass++;
    tick();
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    #1;
    n_total++;
    if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0) $display("FAIL bypass_consumed got cnt=%0d v=%b exp cnt=0 v=0", bus.count, bus.deq_valid);
    else n_pass++;
`else
    n_total++;
    if (bus.deq_valid !== 1'b0 || bus.deq_inst !== NOP) $display("FAIL nobypass_same_cycle got v=%b inst=%h exp v=0 inst=%h", bus.deq_valid, bus.deq_inst, NOP);
    else n_pass++;
    tick();
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    #1;
    n_total++;
    if (bus.deq_valid !== 1'b1 || bus.deq_inst !== 32'h1234_5678 || bus.deq_pc_4 !== 32'h800 || bus.count !== 3'd1)
      $display("FAIL nobypass_next_cycle got v=%b inst=%h pc=%h cnt=%0d exp v=1 inst=12345678 pc=800 cnt=1",
               bus.deq_valid, bus.deq_inst, bus.deq_pc_4, bus.count);
    else n_pass++;
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_pc_4  = 32'(32'h900 + 4 * i);
      bus.enq_inst  = 32'(32'hC0 + i);
      tick();
    end
    bus.enq_valid = 1'b0;
    #1;
    n_total++;
    if (bus.count !== 3'd2) $display("FAIL rstmid_prefill got cnt=%0d exp=2", bus.count);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.enq_ready !== 1'b0) $display("FAIL rstmid_enq_ready_high got=%b exp=0", bus.enq_ready);
    else n_pass++;
    tick();
    n_total++;
    if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.deq_valid !== 1'b0)
      $display("FAIL rstmid_cleared got empty=%b cnt=%0d v=%b exp empty=1 cnt=0 v=0", bus.empty, bus.count, bus.deq_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.enq_ready !== 1'b1) $display("FAIL rstmid_enq_ready_low got=%b exp=1", bus.enq_ready);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_single();
    test_full();
    test_flush();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
